// File: rtl/pong_pkg.sv
// Shared types and constants for the paddle-game sequencer.
package pong_pkg;

    localparam int unsigned SCORE_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable frame-tick down-counter; expire pulses on the tick that takes it from 1 to 0.
module pong_frame_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             run,
    input  logic             frame_tick,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down on ticks while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (run && frame_tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Combinational so the phase change lands on the edge of the expiring tick.
    assign expire = run && frame_tick && (count == WIDTH'(1));

endmodule

// File: rtl/pong_seq.sv
// Match sequencer: FSM, score registers and paddle input divider.
module pong_seq
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned INPUT_DIV    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_tick,
    input  logic         start,
    input  logic         miss_p1,
    input  logic         miss_p2,
    output logic         input_enable,
    output logic         ball_enable,
    output logic         serve_dir,
    output logic [3:0]   score_p1,
    output logic [3:0]   score_p2,
    output logic [2:0]   state,
    output logic [1:0]   winner
);

    localparam int unsigned TIMER_W = $clog2(max2(SERVE_FRAMES, POINT_FRAMES) + 1);
    localparam int unsigned DIV_W   = (INPUT_DIV > 1) ? $clog2(INPUT_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_MAX    = DIV_W'(INPUT_DIV - 1);
    localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_n;
    logic [SCORE_W-1:0] p1_q, p1_n, p2_q, p2_n;
    logic               dir_q, dir_n;
    logic [1:0]         win_q, win_n;
    logic               ball_q, ball_n;
    logic               ie_q, ie_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_run;
    logic               timer_expire;

    assign timer_run = (state_q == SERVE) || (state_q == POINT);

    pong_frame_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .run        (timer_run),
        .frame_tick (frame_tick),
        .expire     (timer_expire)
    );

    // State, score and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            dir_q   <= 1'b1;
            win_q   <= WIN_NONE;
            ball_q  <= 1'b0;
            ie_q    <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_n;
            p1_q    <= p1_n;
            p2_q    <= p2_n;
            dir_q   <= dir_n;
            win_q   <= win_n;
            ball_q  <= ball_n;
            ie_q    <= ie_n;
            div_q   <= div_n;
        end
    end

    // Next-state, scoring, timer control and input divider.
    always_comb begin
        state_n     = state_q;
        p1_n        = p1_q;
        p2_n        = p2_q;
        dir_n       = dir_q;
        win_n       = win_q;
        timer_load  = 1'b0;
        timer_value = SERVE_LOAD;
        div_n       = div_q;
        ie_n        = 1'b0;

        // Divider decision uses the state of the tick cycle, so a miss in
        // the same PLAY cycle still yields the strobe.
        if (frame_tick && ((state_q == SERVE) || (state_q == PLAY))) begin
            if (div_q == DIV_MAX) begin
                div_n = '0;
                ie_n  = 1'b1;
            end else begin
                div_n = div_q + 1'b1;
            end
        end

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_n    = SERVE;
                    p1_n       = '0;
                    p2_n       = '0;
                    win_n      = WIN_NONE;
                    timer_load = 1'b1;
                    div_n      = '0;
                end
            end
            SERVE: begin
                if (timer_expire) state_n = PLAY;
            end
            PLAY: begin
                if (miss_p1 || miss_p2) begin
                    state_n     = POINT;
                    timer_load  = 1'b1;
                    timer_value = POINT_LOAD;
                    if (miss_p1 && !miss_p2) begin
                        p2_n  = p2_q + 1'b1;
                        dir_n = 1'b0;
                    end else if (miss_p2 && !miss_p1) begin
                        p1_n  = p1_q + 1'b1;
                        dir_n = 1'b1;
                    end
                end
            end
            POINT: begin
                if (timer_expire) begin
                    if (p1_q == WIN) begin
                        state_n = OVER;
                        win_n   = WIN_P1;
                    end else if (p2_q == WIN) begin
                        state_n = OVER;
                        win_n   = WIN_P2;
                    end else begin
                        state_n    = SERVE;
                        timer_load = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        ball_n = (state_n == PLAY);
    end

    assign state        = state_q;
    assign score_p1     = p1_q;
    assign score_p2     = p2_q;
    assign serve_dir    = dir_q;
    assign winner       = win_q;
    assign ball_enable  = ball_q;
    assign input_enable = ie_q;

endmodule
